sha3_padder_p: RTL

SHA3_PADDER_P -- requirements
Module: sha3_padder_p

---
 rtl/sha3_pkg.sv | 23 ++
 rtl/sha3_pad_word.sv | 26 ++
 rtl/sha3_padder_p.sv | 115 +++++++++++
 3 files changed

// File: rtl/sha3_pkg.sv
// Shared constants and state encoding for the SHA-3 / Keccak message padder.
package sha3_pkg;

  localparam logic [7:0] SUFFIX_KECCAK = 8'h01;
  localparam logic [7:0] SUFFIX_SHA3   = 8'h06;
  localparam logic [7:0] SUFFIX_SHAKE  = 8'h1F;
  localparam logic [7:0] PAD_END       = 8'h80;

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_PAD    = 2'd1,
    ST_FULL   = 2'd2
  } state_t;

  function automatic logic [7:0] suffix_byte(input logic [1:0] sel);
    case (sel)
      2'd0:    suffix_byte = SUFFIX_KECCAK;
      2'd2:    suffix_byte = SUFFIX_SHAKE;
      default: suffix_byte = SUFFIX_SHA3;
    endcase
  endfunction

endpackage

// File: rtl/sha3_pad_word.sv
// Builds the final message word: leading valid bytes kept, domain suffix
// placed right after them, remaining lower bytes zeroed (byte 0 is the MSB byte).
module sha3_pad_word #(
  parameter int W    = 32,
  parameter int BN_W = $clog2(W/8)
) (
  input  logic [W-1:0]    in,
  input  logic [BN_W-1:0] byte_num,
  input  logic [7:0]      suffix,
  output logic [W-1:0]    out
);

  localparam int NB = W / 8;

  always_comb begin
    out = '0;
    for (int b = 0; b < NB; b++) begin
      if (BN_W'(b) < byte_num) begin
        out[W-1-8*b -: 8] = in[W-1-8*b -: 8];
      end else if (BN_W'(b) == byte_num) begin
        out[W-1-8*b -: 8] = suffix;
      end
    end
  end

endmodule

// File: rtl/sha3_padder_p.sv
// Collects message words into one rate block, applies suffix and 0x80 end
// padding, and holds the block until the consumer acknowledges it.
module sha3_padder_p
  import sha3_pkg::*;
#(
  parameter int W          = 32,
  parameter int RATE_WORDS = 18,
  parameter int BN_W       = $clog2(W/8)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [W-1:0]            in,
  input  logic                    in_ready,
  input  logic                    is_last,
  input  logic [BN_W-1:0]         byte_num,
  input  logic [1:0]              suffix_sel,
  output logic                    buffer_full,
  output logic [W*RATE_WORDS-1:0] out,
  output logic                    out_ready,
  input  logic                    f_ack
);

  localparam int OW = W * RATE_WORDS;
  localparam int IW = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;
  localparam logic [IW-1:0] LAST_SLOT = IW'(RATE_WORDS - 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   i_q, i_d;
  logic            last_seen_q, last_seen_d;
  logic [OW-1:0]   buf_q, buf_d;

  logic [7:0]      suffix;
  logic [W-1:0]    padded_word;
  logic            store;
  logic [W-1:0]    store_word;

  assign suffix = suffix_byte(suffix_sel);

  sha3_pad_word #(.W(W), .BN_W(BN_W)) u_pad_word (
    .in       (in),
    .byte_num (byte_num),
    .suffix   (suffix),
    .out      (padded_word)
  );

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    last_seen_d = last_seen_q;
    buf_d       = buf_q;
    store       = 1'b0;
    store_word  = '0;

    case (state_q)
      ST_ACCEPT: begin
        if (in_ready) begin
          store = 1'b1;
          if (is_last) begin
            store_word  = padded_word;
            last_seen_d = 1'b1;
          end else begin
            store_word = in;
          end
        end
      end
      ST_PAD: begin
        store      = 1'b1;
        store_word = '0;
      end
      ST_FULL: begin
        if (f_ack) begin
          buf_d       = '0;
          i_d         = '0;
          last_seen_d = 1'b0;
          state_d     = ST_ACCEPT;
        end
      end
      default: state_d = ST_ACCEPT;
    endcase

    // The word landing in the last slot closes the block; it carries the
    // end bit only if the message finished inside this block.
    if (store) begin
      if (i_q == LAST_SLOT) begin
        if (last_seen_d) begin
          store_word = store_word | {{(W-8){1'b0}}, PAD_END};
        end
        state_d = ST_FULL;
      end else begin
        i_d     = i_q + IW'(1);
        state_d = last_seen_d ? ST_PAD : ST_ACCEPT;
      end
      buf_d = {buf_q[OW-W-1:0], store_word};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_ACCEPT;
      i_q         <= '0;
      last_seen_q <= 1'b0;
      buf_q       <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      last_seen_q <= last_seen_d;
      buf_q       <= buf_d;
    end
  end

  assign out         = buf_q;
  assign out_ready   = (state_q == ST_FULL);
  assign buffer_full = (state_q == ST_FULL);

endmodule
